uart_tx_fifo: RTL

//  Parametrised UART transmitter with an input FIFO, configurable data width, parity and stop bits.

---
 rtl/uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter fed by a circular-buffer FIFO. Host logic
//                pushes words with a start/ready handshake; frames are
//                serialised back-to-back with no idle gap while words remain.
//                Frame = start(0), DATA_BITS LSB first, optional parity,
//                STOP_BITS ones. Each bit lasts CLK_DIV+1 clk cycles.
//  Ports       : clk, rst (sync, active-high)
//                tbus[DATA_BITS-1:0] word to push, start push request
//                ready FIFO not full (low in reset), overflow dropped push
//                fifo_count[FIFO_AW:0] queued words (excl. frame in flight)
//                busy frame in flight or words queued, tx registered line
//                brk (only with UART_TX_FIFO_BREAK_EN) hold line in break
//  Options     : `define UART_TX_FIFO_BREAK_EN adds the brk input.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIV   = 10416,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_TX_FIFO_BREAK_EN
    input  logic                 brk,
`endif
    input  logic [DATA_BITS-1:0] tbus,
    input  logic                 start,
    output logic                 ready,
    output logic                 overflow,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 busy,
    output logic                 tx
);

    localparam int          c_DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0] c_DIV       = 16'(CLK_DIV);
    localparam logic [3:0]  c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit          c_HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra MSB distinguishes full/empty)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [c_DEPTH];
    logic [FIFO_AW:0]     r_wr_ptr;
    logic [FIFO_AW:0]     r_rd_ptr;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_par_bit;

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [15:0]          r_cnt;
    logic [3:0]           r_bitn;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_guard;
    logic                 r_tx;

    logic                 w_brk;
    logic                 w_tick;
    logic                 w_stop_done;
    logic                 w_idle_go;
    logic                 w_line;

`ifdef UART_TX_FIFO_BREAK_EN
    assign w_brk = brk;
`else
    assign w_brk = 1'b0;
`endif

    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // ready reflects the current full state only, so a push against a full
    // FIFO is refused even when a pop happens on the same edge.
    assign ready      = !w_full && !rst;
    assign w_push     = start && ready;
    assign overflow   = start && !ready && !rst;
    assign fifo_count = r_wr_ptr - r_rd_ptr;
    assign w_rd_data  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // Odd parity makes the total count of ones odd, even makes it even.
    assign w_par_bit  = (PARITY == 1) ? ~(^w_rd_data) : (^w_rd_data);

    assign w_tick      = (r_cnt == c_DIV);
    assign w_stop_done = (r_state == S_STOP) && w_tick && (r_bitn == c_LAST_STOP);
    // After a break the line must idle high for a full bit (r_guard) before
    // the next start bit is allowed.
    assign w_idle_go   = (r_state == S_IDLE) && !w_empty && !w_brk && !r_guard;
    assign w_pop       = w_idle_go || (w_stop_done && !w_empty && !w_brk);

    assign busy = (r_state != S_IDLE) || (fifo_count != '0);
    assign tx   = r_tx;

    // Line level implied by the current state; registered into r_tx, so the
    // serial output trails the state register by exactly one cycle.
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_IDLE:   w_line = !w_brk;
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
            S_PARITY: w_line = r_par;
            S_STOP:   w_line = 1'b1;
            default:  w_line = 1'b1;
        endcase
    end

    // FIFO write port (storage is not reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= tbus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM. r_cnt counts cycles within the current bit and is
    // cleared at every bit boundary; r_bitn counts data or stop bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_guard <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_tx <= w_line;
            case (r_state)
                S_IDLE: begin
                    r_bitn <= '0;
                    if (w_brk) begin
                        r_guard <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_guard) begin
                        if (w_tick) begin
                            r_guard <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else if (w_pop) begin
                        r_shift <= w_rd_data;
                        r_par   <= w_par_bit;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end else begin
                        r_cnt <= '0;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bitn == c_LAST_DATA) begin
                            r_bitn  <= '0;
                            r_state <= c_HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            r_bitn <= r_bitn + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (r_bitn == c_LAST_STOP) begin
                            r_bitn <= '0;
                            // Chain straight into the next frame when a word
                            // is waiting, giving a zero-length idle gap.
                            if (w_pop) begin
                                r_shift <= w_rd_data;
                                r_par   <= w_par_bit;
                                r_state <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_bitn <= r_bitn + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_bitn  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
